// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: 68000 bus slave that decodes an address window, forwards
// each access to an internal request/acknowledge port, inserts MCCLK wait states
// and returns DTACK_n. Optional macro BERR_TIMEOUT_EN adds an ACK timeout that
// answers with BERR_n instead of DTACK_n.
module m68k_bus_responder #(
  parameter logic [22:0] BASE_ADDR   = 23'h7F0000,
  parameter logic [22:0] ADDR_MASK   = 23'h7F0000,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [7:0]  TIMEOUT     = 8'd255
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic        MCCLK_RISING,
  input  logic        MCCLK_FALLING,
  input  logic        AS_n,
  input  logic        UDS_n,
  input  logic        LDS_n,
  input  logic        RW,
  input  logic [22:0] A,
  input  logic [15:0] D_IN,
  output logic        DTACK_n,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  output logic        BERR_n,
  output logic        REQ,
  output logic        REQ_WE,
  output logic [22:0] REQ_ADDR,
  output logic [1:0]  REQ_BE,
  output logic [15:0] REQ_WDATA,
  input  logic        ACK,
  input  logic [15:0] RDATA
);

  localparam int unsigned WAIT_W = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_STATES);

  // S_BERR is only reachable when the ACK timeout is built in
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_ACKED, S_RELEASE, S_BERR
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          strb_meta_q, strb_meta_d;
  logic [3:0]          strb_sync_q, strb_sync_d;
  logic                armed_q, armed_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [22:0]         addr_q, addr_d;
  logic [1:0]          be_q, be_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         d_out_q, d_out_d;
  logic                d_oe_q, d_oe_d;
  logic                dtack_n_q, dtack_n_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
`ifdef BERR_TIMEOUT_EN
  logic                berr_n_q, berr_n_d;
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;
`endif

  logic as_s, uds_s, lds_s, rw_s;
  logic sel_c, ds_any_c, wait_done_c;
  logic unused_c;

  assign as_s  = strb_sync_q[3];
  assign uds_s = strb_sync_q[2];
  assign lds_s = strb_sync_q[1];
  assign rw_s  = strb_sync_q[0];

  assign sel_c       = (A & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
  assign ds_any_c    = ~uds_s | ~lds_s;
  assign wait_done_c = (wait_cnt_q == WAIT_LAST) ||
                       (MCCLK_FALLING && ((wait_cnt_q + WAIT_W'(1)) == WAIT_LAST));

  // Two-flop synchronizer for the asynchronous bus strobes and direction
  always_comb begin
    strb_meta_d = {AS_n, UDS_n, LDS_n, RW};
    strb_sync_d = strb_meta_q;
  end

  // Bus handshake next-state and registered output logic
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q | as_s;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    d_out_d    = d_out_q;
    d_oe_d     = d_oe_q;
    dtack_n_d  = dtack_n_q;
    wait_cnt_d = wait_cnt_q;
`ifdef BERR_TIMEOUT_EN
    berr_n_d   = berr_n_q;
    tmo_cnt_d  = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // armed_q blocks a still-low AS from re-triggering the previous cycle
        if (armed_q && !as_s && ds_any_c && sel_c) begin
          addr_d     = A;
          we_d       = ~rw_s;
          be_d       = {~uds_s, ~lds_s};
          wdata_d    = D_IN;
          req_d      = 1'b1;
          armed_d    = 1'b0;
          wait_cnt_d = '0;
`ifdef BERR_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (ACK) begin
          d_out_d    = RDATA;
          req_d      = 1'b0;
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
`ifdef BERR_TIMEOUT_EN
        else if (tmo_cnt_q == (TIMEOUT - 8'd1)) begin
          req_d    = 1'b0;
          berr_n_d = 1'b0;
          state_d  = S_BERR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      S_WAIT: begin
        // AS seen high since the cycle started means the master gave up
        if (as_s || armed_q) begin
          state_d = S_IDLE;
        end else if (wait_done_c) begin
          dtack_n_d = 1'b0;
          d_oe_d    = ~we_q;
          state_d   = S_ACKED;
        end else if (MCCLK_FALLING) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_ACKED: begin
        if (as_s) begin
          dtack_n_d = 1'b1;
          d_oe_d    = 1'b0;
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      S_BERR: begin
`ifdef BERR_TIMEOUT_EN
        if (as_s) begin
          berr_n_d = 1'b1;
          state_d  = S_RELEASE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared by RESET
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      strb_meta_q <= 4'b1111;
      strb_sync_q <= 4'b1111;
      armed_q     <= 1'b1;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      dtack_n_q   <= 1'b1;
      wait_cnt_q  <= '0;
`ifdef BERR_TIMEOUT_EN
      berr_n_q    <= 1'b1;
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      strb_meta_q <= strb_meta_d;
      strb_sync_q <= strb_sync_d;
      armed_q     <= armed_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      dtack_n_q   <= dtack_n_d;
      wait_cnt_q  <= wait_cnt_d;
`ifdef BERR_TIMEOUT_EN
      berr_n_q    <= berr_n_d;
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign DTACK_n   = dtack_n_q;
  assign D_OUT     = d_out_q;
  assign D_OE      = d_oe_q;
  assign REQ       = req_q;
  assign REQ_WE    = we_q;
  assign REQ_ADDR  = addr_q;
  assign REQ_BE    = be_q;
  assign REQ_WDATA = wdata_q;

`ifdef BERR_TIMEOUT_EN
  assign BERR_n   = berr_n_q;
  assign unused_c = MCCLK_RISING;
`else
  assign BERR_n   = 1'b1;
  assign unused_c = ^{MCCLK_RISING, TIMEOUT};
`endif

endmodule

// File: doc/m68k_bus_responder.md
M68K_BUS_RESPONDER -- requirements
Module: m68k_bus_responder

Interface
REQ-001: Parameter BASE_ADDR, default 23'h7F0000, word address (A[23:1]) of the decoded window.
REQ-002: Parameter ADDR_MASK, default 23'h7F0000, address bits compared against BASE_ADDR.
REQ-003: Parameter WAIT_STATES, default 2, number of MCCLK_FALLING strobes inserted before DTACK.
REQ-004: Parameter TIMEOUT, default 8'd255, SYSCLK cycles allowed for ACK when BERR_TIMEOUT_EN is defined.
REQ-005: SYSCLK  in  1  single block clock; all state updates on its rising edge.
REQ-006: RESET  in  1  asynchronous, active-high reset.
REQ-007: MCCLK_RISING, MCCLK_FALLING  in  1 each  one-SYSCLK strobes of 68000 bus clock edges.
REQ-008: AS_n, UDS_n, LDS_n, RW  in  1 each  asynchronous 68000 bus strobes and direction.
REQ-009: A  in  23  bus address A[23:1]; D_IN  in  16  bus write data.
REQ-010: DTACK_n  out  1  data acknowledge to bus master, active low.
REQ-011: D_OUT  out  16 and D_OE  out  1  read data and its output enable.
REQ-012: BERR_n  out  1  bus error, active low.
REQ-013: REQ, REQ_WE  out  1; REQ_ADDR  out  23; REQ_BE  out  2 ({UDS,LDS} active); REQ_WDATA  out  16  internal request port.
REQ-014: ACK  in  1 and RDATA  in  16  internal completion pulse and read data.

Function
REQ-015: AS_n, UDS_n, LDS_n and RW shall pass a 2-flop synchronizer; A and D_IN are sampled when the synchronized strobes qualify.
REQ-016: States: IDLE, REQ, WAIT, ACKED, RELEASE.
REQ-017: IDLE->REQ when synced AS low, at least one DS low, and (A & ADDR_MASK) == (BASE_ADDR & ADDR_MASK); latch A, RW, BE and D_IN in the same cycle; REQ asserts on the next cycle.
REQ-018: REQ shall stay high with stable REQ_* outputs until the cycle ACK is high; RDATA is captured into D_OUT in that cycle; REQ drops on the next cycle; then go to WAIT.
REQ-019: ACK while REQ is low shall be ignored.
REQ-020: WAIT counts MCCLK_FALLING strobes; after WAIT_STATES strobes (WAIT_STATES=0: immediately) go to ACKED.
REQ-021: In ACKED, DTACK_n = 0; D_OE = 1 only for reads (RW=1); hold until synced AS high.
REQ-022: Synced AS high in ACKED: DTACK_n = 1 and D_OE = 0 on the next cycle, then RELEASE for one cycle, then IDLE.
REQ-023: AS deasserted during REQ: the handshake completes (no abort of internal port), then the FSM returns to IDLE without asserting DTACK_n.
REQ-024: AS deasserted during WAIT: go to IDLE next cycle; DTACK_n stays high.
REQ-025: A new cycle is not accepted until synced AS has been seen high (RELEASE/IDLE), so back-to-back cycles never merge.
REQ-026: Unselected addresses: no REQ, DTACK_n, D_OE or BERR_n activity.

Reset
REQ-027: RESET asynchronously forces IDLE, DTACK_n = 1, BERR_n = 1, D_OE = 0, REQ = 0, D_OUT = 0, counters and synchronizers to idle (strobes high).
REQ-028: RESET mid-cycle drops REQ and DTACK_n at once; a later ACK pulse shall be ignored.

Configuration
REQ-029: With BERR_TIMEOUT_EN defined, an 8-bit counter runs in REQ; at TIMEOUT cycles without ACK, REQ drops, BERR_n = 0 until synced AS high, and DTACK_n stays high.
REQ-030: Without BERR_TIMEOUT_EN, BERR_n is constant 1, no counter exists, and REQ waits indefinitely.

Verification
REQ-031: Read at 0x7F0010, ACK after 3 cycles with RDATA=16'hBEEF, WAIT_STATES=2 -> DTACK_n low after 2nd MCCLK_FALLING, D_OUT=BEEF, D_OE=1, both released after AS high.
REQ-032: Word write D_IN=16'h1234, UDS/LDS low -> REQ_WE=1, REQ_BE=2'b11, REQ_WDATA=1234, D_OE stays 0.
REQ-033: Access at 0x000100 -> REQ, DTACK_n, BERR_n never asserted.
REQ-034: AS raised during WAIT -> IDLE, DTACK_n never low; next selected cycle serviced normally.
REQ-035: BERR_TIMEOUT_EN, no ACK -> BERR_n low exactly 255 cycles after REQ rose, REQ low, cleared on AS high.
REQ-036: RESET pulsed while REQ high, then ACK -> all outputs at reset values, no DTACK_n.
